// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access engine. Runs one load or store per accepted start
// pulse over a word-wide, variable-latency bus. Byte stores use read-modify-write; byte
// loads select a little-endian lane and zero/sign-extend it. All outputs are registered.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start                      request pulse, sampled only in idle
//   mem_rd, mem_wr             load / store request
//   ltype                      1 = 16-bit word access, 0 = byte access
//   m                          byte-load extension: 0 = zero, 1 = sign
//   addr, wdata                byte address, store data (byte store uses wdata[7:0])
//   busy, done                 transaction in progress, one-cycle completion pulse
//   load_data, err             load result and error flag, held until next accepted start
//   bus_req, bus_we            bus request and write strobe
//   bus_addr, bus_wdata        word address (addr[15:1]) and write data
//   bus_rdata, bus_ack         read data and single-cycle acknowledge
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        ltype,
    input  logic        m,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] load_data,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [14:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [2:0] {StIdle, StRd, StMerge, StWr, StDone} state_e;

    // Last cycle of waiting: an ack here still wins, no ack aborts.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_load_q, is_load_d;
    logic             word_q, word_d;
    logic             sign_q, sign_d;
    logic             lane_q, lane_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [15:0]      load_data_d, bus_wdata_d;
    logic [14:0]      bus_addr_d;
    logic             err_d, busy_d, done_d, bus_req_d, bus_we_d;

    logic [7:0]       lane_byte;
    logic [15:0]      byte_ext;
    logic [15:0]      merged;

    assign lane_byte = lane_q ? bus_rdata[15:8] : bus_rdata[7:0];
    assign byte_ext  = {{8{sign_q & lane_byte[7]}}, lane_byte};
    assign merged    = lane_q ? {wbyte_q, bus_rdata[7:0]} : {bus_rdata[15:8], wbyte_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        word_d      = word_q;
        sign_d      = sign_q;
        lane_d      = lane_q;
        wbyte_d     = wbyte_q;
        load_data_d = load_data;
        bus_wdata_d = bus_wdata;
        bus_addr_d  = bus_addr;
        err_d       = err;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_load_d  = mem_rd;
                    word_d     = ltype;
                    sign_d     = m;
                    lane_d     = addr[0];
                    wbyte_d    = wdata[7:0];
                    bus_addr_d = addr[15:1];
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    if (mem_rd && mem_wr) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (!mem_rd && !mem_wr) begin
                        state_d = StDone;
                    end else if (ltype && addr[0]) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (mem_rd || !ltype) begin
                        // Loads and byte stores both start with a read.
                        state_d = StRd;
                    end else begin
                        state_d     = StWr;
                        bus_wdata_d = wdata;
                    end
                end
            end
            StRd: begin
                if (bus_ack) begin
                    if (is_load_q) begin
                        load_data_d = word_q ? bus_rdata : byte_ext;
                        state_d     = StDone;
                    end else begin
                        bus_wdata_d = merged;
                        state_d     = StMerge;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (is_load_q) begin
                        load_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMerge: begin
                state_d = StWr;
                cnt_d   = '0;
            end
            StWr: begin
                if (bus_ack) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status/bus outputs are a registered decode of the next state.
        busy_d    = (state_d == StRd) || (state_d == StMerge) || (state_d == StWr);
        done_d    = (state_d == StDone);
        bus_req_d = (state_d == StRd) || (state_d == StWr);
        bus_we_d  = (state_d == StWr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            word_q    <= 1'b0;
            sign_q    <= 1'b0;
            lane_q    <= 1'b0;
            wbyte_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            load_data <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            word_q    <= word_d;
            sign_q    <= sign_d;
            lane_q    <= lane_d;
            wbyte_q   <= wbyte_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            load_data <= load_data_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a negedge bus responder.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_rd;
    logic        mem_wr;
    logic        ltype;
    logic        m;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] load_data;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [14:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    // Responder configuration (written by tests) and its observations.
    logic        ack_en;
    int          ack_wait;
    logic [15:0] rd_word;
    int          wait_cnt;
    int          rd_count;
    int          wr_count;
    logic [15:0] last_wdata;
    logic [14:0] last_waddr;

    int checks;
    int errors;

    mem_access_unit #(
        .TIMEOUT(15),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .ltype    (ltype),
        .m        (m),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .load_data(load_data),
        .err      (err),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Acks after ack_wait wait cycles of bus_req; one-cycle ack pulse.
    initial begin
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        wait_cnt   = 0;
        rd_count   = 0;
        wr_count   = 0;
        last_wdata = '0;
        last_waddr = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req && ack_en) begin
                if (wait_cnt == ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_word;
                    wait_cnt  = 0;
                    if (bus_we) begin
                        wr_count++;
                        last_wdata = bus_wdata;
                        last_waddr = bus_addr;
                    end else begin
                        rd_count++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Issues one start at cycle 0 and reports the done cycle, bus_req-high cycles,
    // busy cycles with bus_req low, and bus_addr in cycle 1. Returns during the done cycle.
    task automatic run_op(input logic rd, input logic wr, input logic lt, input logic mm,
                          input logic [15:0] a, input logic [15:0] wd,
                          output int dc, output int reqc, output int gapc,
                          output logic [14:0] addr_seen);
        @(posedge clk);
        @(negedge clk);
        mem_rd = rd;
        mem_wr = wr;
        ltype  = lt;
        m      = mm;
        addr   = a;
        wdata  = wd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dc        = -1;
        reqc      = 0;
        gapc      = 0;
        addr_seen = bus_addr;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            if (bus_req) reqc++;
            else if (busy) gapc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, bus_req, bus_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, bus_req, bus_we});
        end
        checks++;
        if ({load_data, bus_addr, bus_wdata} !== 47'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", load_data, bus_addr, bus_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_load();
        int dc, reqc, gapc;
        logic [14:0] as;
        ack_en = 1'b1; ack_wait = 0; rd_word = 16'hBEEF;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (as !== 15'h0008) begin
            errors++; $display("FAIL wl_addr: got %h expected 0008", as);
        end
        checks++;
        if (dc !== 2) begin
            errors++; $display("FAIL wl_done_cycle: got %0d expected 2", dc);
        end
        checks++;
        if (load_data !== 16'hBEEF || err !== 1'b0) begin
            errors++; $display("FAIL wl_data: got %h err %b expected beef err 0", load_data, err);
        end
    endtask

    task automatic test_byte_load();
        int dc, reqc, gapc;
        logic [14:0] as;
        logic [15:0] a_tab [3];
        logic        m_tab [3];
        logic [15:0] e_tab [3];
        a_tab = '{16'h0011, 16'h0011, 16'h0010};
        m_tab = '{1'b1, 1'b0, 1'b1};
        e_tab = '{16'hFF80, 16'h0080, 16'hFFFF};
        ack_en = 1'b1; ack_wait = 0; rd_word = 16'h80FF;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, 1'b0, m_tab[i], a_tab[i], 16'h0000, dc, reqc, gapc, as);
            checks++;
            if (dc !== 2 || load_data !== e_tab[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL bl_%0d: got done@%0d data %h err %b expected done@2 data %h err 0",
                         i, dc, load_data, err, e_tab[i]);
            end
        end
    endtask

    task automatic test_word_store();
        int dc, reqc, gapc, w0;
        logic [14:0] as;
        logic [15:0] ld0;
        ack_en = 1'b1; ack_wait = 0;
        w0  = wr_count;
        ld0 = load_data;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h1234, dc, reqc, gapc, as);
        checks++;
        if (dc !== 2 || reqc !== 1) begin
            errors++; $display("FAIL ws_timing: got done@%0d req %0d expected done@2 req 1", dc, reqc);
        end
        checks++;
        if (wr_count - w0 !== 1 || last_wdata !== 16'h1234 || last_waddr !== 15'h0020) begin
            errors++;
            $display("FAIL ws_bus: got %0d writes %h@%h expected 1 write 1234@0020",
                     wr_count - w0, last_wdata, last_waddr);
        end
        checks++;
        if (load_data !== ld0) begin
            errors++; $display("FAIL ws_load_data: got %h expected %h", load_data, ld0);
        end
    endtask

    task automatic test_byte_store();
        int dc, reqc, gapc, r0, w0;
        logic [14:0] as;
        logic [15:0] ld0;
        ack_en = 1'b1; ack_wait = 2; rd_word = 16'hAABB;
        r0  = rd_count;
        w0  = wr_count;
        ld0 = load_data;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0012, dc, reqc, gapc, as);
        // 3 read cycles, 1 merge, 3 write cycles, done at cycle 8.
        checks++;
        if (dc !== 8 || reqc !== 6 || gapc !== 1) begin
            errors++;
            $display("FAIL bs_timing: got done@%0d req %0d gap %0d expected done@8 req 6 gap 1",
                     dc, reqc, gapc);
        end
        checks++;
        if (rd_count - r0 !== 1 || wr_count - w0 !== 1) begin
            errors++;
            $display("FAIL bs_count: got %0d reads %0d writes expected 1 1",
                     rd_count - r0, wr_count - w0);
        end
        checks++;
        if (last_wdata !== 16'h12BB || last_waddr !== 15'h0010 || err !== 1'b0) begin
            errors++;
            $display("FAIL bs_data: got %h@%h err %b expected 12bb@0010 err 0",
                     last_wdata, last_waddr, err);
        end
        checks++;
        if (load_data !== ld0) begin
            errors++; $display("FAIL bs_load_data: got %h expected %h", load_data, ld0);
        end
    endtask

    task automatic test_illegal();
        int dc, reqc, gapc;
        logic [14:0] as;
        ack_en = 1'b1; ack_wait = 0;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h5555, dc, reqc, gapc, as);
        checks++;
        if (dc !== 1 || reqc !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned: got done@%0d req %0d err %b expected done@1 req 0 err 1",
                     dc, reqc, err);
        end
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (dc !== 1 || reqc !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL rd_and_wr: got done@%0d req %0d err %b expected done@1 req 0 err 1",
                     dc, reqc, err);
        end
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (dc !== 1 || reqc !== 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL noop: got done@%0d req %0d err %b expected done@1 req 0 err 0",
                     dc, reqc, err);
        end
    endtask

    task automatic test_timeout();
        int dc, reqc, gapc;
        logic [14:0] as;
        ack_en = 1'b0;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (dc !== 16 || reqc !== 15) begin
            errors++;
            $display("FAIL to_timing: got done@%0d req %0d expected done@16 req 15", dc, reqc);
        end
        checks++;
        if (err !== 1'b1 || load_data !== 16'h0000) begin
            errors++;
            $display("FAIL to_result: got err %b data %h expected err 1 data 0000", err, load_data);
        end
        ack_en = 1'b1; ack_wait = 0; rd_word = 16'h1357;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (dc !== 2 || err !== 1'b0 || load_data !== 16'h1357) begin
            errors++;
            $display("FAIL to_followup: got done@%0d err %b data %h expected done@2 err 0 1357",
                     dc, err, load_data);
        end
        // Ack in the 15th request cycle arrives together with the limit and must win.
        ack_wait = 14; rd_word = 16'h2468;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        checks++;
        if (dc !== 16 || err !== 1'b0 || load_data !== 16'h2468) begin
            errors++;
            $display("FAIL to_ack_wins: got done@%0d err %b data %h expected done@16 err 0 2468",
                     dc, err, load_data);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        ack_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b1; ltype = 1'b1; m = 1'b0;
        addr = 16'h0050; wdata = 16'hCAFE; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1) begin
            errors++; $display("FAIL rm_in_wr: got req %b we %b expected 1 1", bus_req, bus_we);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || load_data !== 16'h0000) begin
            errors++;
            $display("FAIL rm_abort: got req %b busy %b data %h expected 0 0 0000",
                     bus_req, busy, load_data);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done || bus_req) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL rm_quiet: got %0d active cycles expected 0", seen_done);
        end
    endtask

    task automatic test_start_in_done();
        int dc, reqc, gapc, quiet;
        logic [14:0] as;
        ack_en = 1'b1; ack_wait = 0; rd_word = 16'h0F0F;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, reqc, gapc, as);
        // Now inside the done cycle: this start must be dropped.
        start  = 1'b1;
        mem_rd = 1'b1;
        mem_wr = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        quiet = 0;
        for (int c = 0; c < 3; c++) begin
            if (busy || bus_req || done) quiet++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dc !== 2 || quiet !== 0) begin
            errors++;
            $display("FAIL start_in_done: got done@%0d active %0d expected done@2 active 0",
                     dc, quiet);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        ltype  = 1'b0;
        m      = 1'b0;
        addr   = '0;
        wdata  = '0;
        ack_en = 1'b0;
        ack_wait = 0;
        rd_word  = '0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_word_store();
        test_byte_store();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_start_in_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
